// File: rtl/div_unit_pkg.sv
// Shared mult/div pipeline definitions: FSM encoding, iteration count and
// HI/LO field positions of the 64-bit result.
package div_unit_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;

  // HI holds the remainder, LO holds the quotient
  localparam int LO_LSB = 0;
  localparam int LO_MSB = 31;
  localparam int HI_LSB = 32;
  localparam int HI_MSB = 63;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage and the divider.
interface div_unit_if;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        div_en;
  logic        unsigned_instr;
  logic [63:0] div_result;
  logic        busy;
  logic        done;

  modport master (output op1, op2, div_en, unsigned_instr,
                  input  div_result, busy, done);
  modport slave  (input  op1, op2, div_en, unsigned_instr,
                  output div_result, busy, done);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (div/divu). One quotient bit per cycle on
// operand magnitudes, sign fix-up in a final cycle, registered HI/LO result.
module div_unit #(
  parameter int DIV_CYCLES = div_unit_pkg::DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);
  import div_unit_pkg::*;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0]   rem_q, rem_d;     // partial remainder
  logic [31:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [31:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [31:0]   op1_q, op1_d;     // original dividend for the /0 case
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic [63:0]   res_q, res_d;

  // operand magnitudes and step arithmetic
  logic [31:0] a_mag, b_mag, q_fix, r_fix;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        borrow, accept;

  assign accept = bus.div_en && (state_q == S_IDLE || state_q == S_DONE);
  assign a_mag  = (bus.unsigned_instr || !bus.op1[31]) ? bus.op1 : (~bus.op1 + 32'd1);
  assign b_mag  = (bus.unsigned_instr || !bus.op2[31]) ? bus.op2 : (~bus.op2 + 32'd1);
  assign rem_sh = {rem_q[31:0], quo_q[31]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign borrow = diff[33];
  assign q_fix  = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix  = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  // next-state: accept, iterate, sign fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    op1_d   = op1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          op1_d   = bus.op1;
          qneg_d  = !bus.unsigned_instr && (bus.op1[31] ^ bus.op2[31]);
          rneg_d  = !bus.unsigned_instr && bus.op1[31];
          dz_d    = (bus.op2 == 32'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = borrow ? rem_sh : diff[32:0];
        quo_d = {quo_q[30:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // a zero divisor bypasses sign handling: all-ones quotient, dividend back
        if (dz_q) begin
          res_d[HI_MSB:HI_LSB] = op1_q;
          res_d[LO_MSB:LO_LSB] = 32'hFFFF_FFFF;
        end else begin
          res_d[HI_MSB:HI_LSB] = r_fix;
          res_d[LO_MSB:LO_LSB] = q_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      op1_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      op1_q   <= op1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy       = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done       = (state_q == S_DONE);
  assign bus.div_result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected {HI,LO} and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_div_unit;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;
  int   last_done = 0;
  int   busy_n;
  exp_t sb[$];

  div_unit_if bus();

  div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: every done pulse must match the oldest outstanding request
  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, bus.div_result, e.res);
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
      last_done = cyc;
    end
  end

  // drive one request; it is accepted on the next rising edge
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic [63:0] exp);
    exp_t e;
    bus.op1 = a; bus.op2 = b; bus.unsigned_instr = uns; bus.div_en = 1'b1;
    @(posedge clk);
    #1;
    e.res = exp; e.cyc = cyc + 33; e.name = name;
    sb.push_back(e);
    bus.div_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int b_done;
    rst_n = 1'b0;
    bus.op1 = '0; bus.op2 = '0; bus.unsigned_instr = 1'b0; bus.div_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_result", bus.div_result, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // first accept on the first edge after release; busy spans 33 cycles
    issue("divu_100_7", 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    busy_n = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy !== 1'b1) break;
      busy_n++;
    end
    chk("busy_cycles", 64'(busy_n), 64'd33);
    drain();

    issue("div_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); drain();
    issue("div_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b0, {32'h0000_0001, 32'hFFFF_FFFD}); drain();
    issue("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0,         32'h8000_0000}); drain();
    issue("divu_max_1", 32'hFFFF_FFFF, 32'd1,          1'b1, {32'h0,         32'hFFFF_FFFF}); drain();
    issue("div_5_0",    32'd5,         32'd0,          1'b0, {32'd5,         32'hFFFF_FFFF}); drain();
    issue("divu_max_0", 32'hFFFF_FFFF, 32'd0,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFF}); drain();
    issue("div_m100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, {32'hFFFF_FFFE, 32'h0000_000E}); drain();
    issue("divu_max_16",32'hFFFF_FFFF, 32'd16,         1'b1, {32'h0000_000F, 32'h0FFF_FFFF}); drain();

    // div_en while busy is ignored; result holds the previous value in CALC
    issue("div_1000_10", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100});
    repeat (10) @(posedge clk);
    #1;
    chk("hold_in_calc", bus.div_result, {32'h0000_000F, 32'h0FFF_FFFF});
    bus.op1 = 32'd77; bus.op2 = 32'd3; bus.unsigned_instr = 1'b1; bus.div_en = 1'b1;
    @(posedge clk); #1 bus.div_en = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // back-to-back accept in DONE: next done pulse 34 cycles later
    issue("divu_50_5", 32'd50, 32'd5, 1'b1, {32'd0, 32'd10});
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    b_done = cyc;
    issue("div_m9_4", 32'hFFFF_FFF7, 32'd4, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    drain();
    chk("b2b_spacing", 64'(last_done - b_done), 64'd34);

    // reset mid-CALC aborts with no done pulse afterwards
    bus.op1 = 32'd1234; bus.op2 = 32'd5; bus.unsigned_instr = 1'b1; bus.div_en = 1'b1;
    @(posedge clk); #1 bus.div_en = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", bus.div_result, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have the following ports, one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op1  input  32  dividend (rs); sampled only on the accept edge.
REQ-005 op2  input  32  divisor (rt); sampled only on the accept edge.
REQ-006 div_en  input  1  start request (div/divu issued); accepted only in IDLE or DONE.
REQ-007 unsigned_instr  input  1  1 = divu, 0 = div (two's complement); sampled with operands.
REQ-008 div_result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-009 busy  output  1  high while a division is in progress (CALC or FIX).
REQ-010 done  output  1  one-cycle pulse; div_result valid and stable from this cycle on.
REQ-011 Parameter DIV_CYCLES, default 32, number of iterations; equal to the operand width.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC, FIX and DONE; busy = (CALC|FIX); done = DONE.
REQ-013 Accept edge: div_en=1 in IDLE or DONE -> latch |op1|, |op2| (magnitude when signed), quotient sign = op1[31]^op2[31], remainder sign = op1[31], zero-divisor flag, and original op1; iteration counter = 0; -> CALC.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle (partial remainder 33 bits, trial subtract of divisor magnitude, quotient bit = no-borrow); after DIV_CYCLES steps -> FIX.
REQ-015 FIX SHALL apply the signs (quotient negated if sign set; remainder negated if op1 negative; signed mode only), write div_result, and -> DONE.
REQ-016 Latency: accept at edge k -> done high in the cycle following edge k+DIV_CYCLES+1 (k+33 for 32); DONE -> IDLE on the next edge unless a new div_en is accepted.
REQ-017 div_en while busy SHALL be ignored; operands and mode of the running division are unaffected.
REQ-018 div_result SHALL hold its last value until the next FIX; it SHALL NOT change during CALC.
REQ-019 Division semantics: quotient truncates toward zero; remainder has the sign of the dividend; |remainder| < |divisor|.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (no trap).
REQ-021 Divisor 0 (either mode) SHALL yield quotient 0xFFFFFFFF, remainder = original op1, with the normal full latency.
REQ-022 All magnitude and negation arithmetic SHALL be 32-bit modulo; the partial remainder SHALL use 33 bits to avoid overflow on 0xFFFFFFFF operands.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, div_result=0, and clear the counter and datapath registers.
REQ-024 Reset mid-operation SHALL abort the division; no done pulse is produced for it after release.
REQ-025 The first accept SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-026 The state enumeration, DIV_CYCLES and the HI/LO field positions SHALL be placed in the shared pipeline package used by the mult/div units.
REQ-027 No sub-module SHALL be created; the iteration datapath, sign handling and FSM reside in div_unit (approximately 150-250 lines).
REQ-028 The interface SHALL mirror the multiply unit (op1/op2/unsigned_instr, 64-bit HI/LO result) so that the EX stage muxes both onto HI/LO.

Verification
REQ-029 divu 100 / 7 -> done at accept+33, div_result = {32'd2, 32'd14}; busy high for exactly 33 cycles.
REQ-030 div -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; div 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-031 div 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}; divu 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
REQ-032 div 5 / 0 and divu 0xFFFFFFFF / 0 -> quotient 0xFFFFFFFF, remainder = op1, with normal latency.
REQ-033 Second div_en (with different operands) 10 cycles into a division -> ignored; first result unchanged; accepting back-to-back in DONE -> next done pulse at +34 cycles.
REQ-034 rst_n pulsed low at CALC cycle 10 -> busy=0, done=0, div_result=0 immediately; no done pulse follows.
